hex_display_ctrl: RTL and testbench
===================================

Name: hex_display_ctrl

Overview:
Downstream consumer of the CPU's HEX write port (gpio_we / gpio_wdata, produced by csrrw to io2). Captures each written 32-bit word and drives eight active-low seven-segment digits. Hex mode updates one cycle after capture. Decimal mode runs an iterative double-dabble conversion: one bit per cycle, with leading-zero blanking and an overflow indication.

Parameters:
CONV_CYCLES, 32, number of double-dabble shift steps; equals the data width.
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 is never blanked); 0 = show all digits.

Ports:
clk  input  1  clock
rst_n  input  1  reset
gpio_we  input  1  write strobe from CPU; one-cycle pulse per write
gpio_wdata  input  32  value to display; sampled when gpio_we=1
dec_mode  input  1  0 = hex display, 1 = unsigned decimal; sampled with gpio_we
busy  output  1  decimal conversion in progress
hex0..hex7  output  7 each  segments {g,f,e,d,c,b,a}, active-low; hex0 = least significant digit

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - On reset: all hexN = 7'b1111111 (dark), busy=0, FSM in IDLE.
  - Reset mid-conversion aborts the conversion with no output update.
- FSM states: IDLE, CONV, SHOW.
- Capture: on a rising edge with gpio_we=1, latch gpio_wdata into val_q and dec_mode into mode_q.
- Hex mode (mode_q=0):
  - FSM stays/returns to IDLE.
  - Digit N = val_q[4N+3:4N], encoded through the hex segment table.
  - Outputs registered; update on the first edge after the capture edge.
- Decimal mode (mode_q=1):
  - IDLE→CONV; step counter cleared, BCD register (40 bits, 10 digits) cleared.
  - busy=1 from the cycle after the capture edge.
  - Each CONV cycle: every BCD nibble ≥5 gets +3, then {bcd,shift} shifts left by 1.
  - After CONV_CYCLES steps → SHOW. SHOW lasts one cycle: outputs register and busy drops on that edge.
  - Outputs update on edge capture+CONV_CYCLES+1 (33 edges after capture for the default).
- Overflow: in decimal mode, if BCD digits 9 or 8 are nonzero (value ≥ 100_000_000), all eight digits = 7'b0111111 (dash). Blanking does not apply.
- Blanking (BLANK_LZ=1), both modes:
  - Digits above the highest nonzero digit show 7'b1111111.
  - A value of 0 shows "0" on hex0 only.
- Segment table, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit).
- Simultaneous events:
  - gpio_we during CONV or SHOW restarts capture with the new word and mode (latest write wins). The old result is never displayed.
  - gpio_we in hex mode during CONV aborts the conversion: hex result shown next edge, busy=0.
- Outputs hold their last displayed value until the next completed update.
- gpio_wdata and dec_mode are ignored when gpio_we=0.

Decomposition:
- Package hex_display_pkg:
  - state enum (IDLE, CONV, SHOW)
  - SEG_BLANK, SEG_DASH constants
  - 16-entry segment table function seg7_encode(logic [3:0])
- Sub-module bin2bcd_seq: iterative double-dabble with start/val/busy/done/bcd[39:0].
- Top instantiates bin2bcd_seq and holds the capture, mode, blanking and output registers.

Test Plan:
- Reset 3 cycles with gpio_we=0 → all hexN=7F, busy=0. Release reset, idle 10 cycles → no change.
- gpio_we, dec_mode=0, wdata=0x12AB00F0 → next edge: hex7..hex0 = 79,24,08,03,40,40,0E,40; busy stays 0.
- gpio_we, dec_mode=1, wdata=12345 →
  - busy=1 for 33 cycles (32 CONV + 1 SHOW).
  - At edge 33 after capture: hex4..hex0 = 79,24,30,19,12; hex7..hex5 = 7F.
  - Outputs unchanged before edge 33.
- dec_mode=1, wdata=0xFFFFFFFF → after 33 edges all hexN=3F. Then wdata=99_999_999 → all hexN=10.
- Start decimal 12345; at CONV step 10 write dec_mode=1, wdata=0 → busy restarts. 33 edges later hex0=40, others 7F; 12345 never appears.
- Start decimal conversion, assert rst_n=0 at step 5 → all outputs 7F, busy=0. A hex write after release displays normally next edge.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types and helpers for the HEX display controller.
//   state_e      : controller FSM states (IDLE, CONV, SHOW)
//   SEG_BLANK    : all segments dark (active-low)
//   SEG_DASH     : only segment g lit, shown on decimal overflow
//   BCD_W        : width of the 10-digit BCD result
//   seg7_encode  : nibble -> {g,f,e,d,c,b,a} active-low segment pattern
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam int         BCD_W     = 40;

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : load val_i and begin a fresh conversion (wins over abort_i)
//   abort_i    : drop any conversion in progress
//   val_i      : binary value to convert, sampled with start_i
//   busy_o     : conversion in progress
//   done_o     : high during the cycle in which the final step is applied;
//                bcd_o holds the complete result from the following cycle
//   bcd_o      : 10-digit BCD result, digit 0 in bits [3:0]
module bin2bcd_seq
  import hex_display_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [W-1:0]     val_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             last_step;

  // One double-dabble step: correct every nibble >= 5 by +3, then shift the
  // combined {bcd, binary} register left by one.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_d, shift_d} = {adj, shift_q} << 1;
  end

  assign last_step = busy_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start_i) begin
      shift_q <= val_i;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (abort_i) begin
      busy_q  <= 1'b0;
    end else if (busy_q) begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_q + CW'(1);
      if (last_step) busy_q <= 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_step && !start_i && !abort_i;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/hex_display_ctrl.sv
// Eight-digit seven-segment controller fed by the CPU HEX write port.
//   clk, rst_n     : clock, synchronous active-low reset
//   gpio_we        : one-cycle write strobe; gpio_wdata/dec_mode sampled with it
//   gpio_wdata     : word to display
//   dec_mode       : 0 = hex digits, 1 = unsigned decimal
//   busy           : decimal conversion in progress
//   hex0..hex7     : active-low segments {g,f,e,d,c,b,a}, hex0 least significant
//   dbg_state      : current controller state, for observation only
// Handshake: the write port has no backpressure. Every cycle with gpio_we=1 is
// accepted; a new write always replaces whatever is in flight (latest wins),
// and busy is advisory only.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int CONV_CYCLES = 32,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gpio_we,
  input  logic [31:0] gpio_wdata,
  input  logic        dec_mode,
  output logic        busy,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output state_e      dbg_state
);

  state_e           state_q, state_d;
  logic [31:0]      val_q;
  logic             mode_q;
  logic             hex_pend_q;
  logic [7:0][6:0]  seg_q, seg_new;
  logic             seg_upd;

  logic             bcd_busy, bcd_done;
  logic [BCD_W-1:0] bcd;

  logic [31:0]      digits;
  logic             ovf;
  logic             lead;
  logic [3:0]       nib;

  bin2bcd_seq #(.W(CONV_CYCLES)) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (gpio_we && dec_mode),
    .abort_i (gpio_we && !dec_mode),
    .val_i   (gpio_wdata[CONV_CYCLES-1:0]),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Any write restarts from scratch: decimal goes (back) to CONV, hex to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gpio_we && dec_mode) state_d = CONV;
      CONV: begin
        if (gpio_we)                     state_d = dec_mode ? CONV : IDLE;
        else if (bcd_done || !bcd_busy)  state_d = SHOW;
      end
      SHOW: state_d = (gpio_we && dec_mode) ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Digit source follows the captured mode: raw nibbles for hex, the low eight
  // BCD digits for decimal. Scanning from the top, digits stay blank until the
  // first nonzero one; digit 0 always ends the blank run.
  always_comb begin
    digits  = mode_q ? bcd[31:0] : val_q;
    ovf     = mode_q && (bcd[39:32] != 8'h00);
    lead    = 1'b1;
    nib     = 4'h0;
    seg_new = '0;
    for (int i = 7; i >= 0; i--) begin
      nib = digits[4*i +: 4];
      if (nib != 4'h0 || i == 0) lead = 1'b0;
      if (ovf)                   seg_new[i] = SEG_DASH;
      else if (BLANK_LZ && lead) seg_new[i] = SEG_BLANK;
      else                       seg_new[i] = seg7_encode(nib);
    end
  end

  // A write arriving in SHOW supersedes the finished result, so it is dropped.
  assign seg_upd = hex_pend_q || (state_q == SHOW && !gpio_we);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val_q      <= '0;
      mode_q     <= 1'b0;
      hex_pend_q <= 1'b0;
      seg_q      <= {8{SEG_BLANK}};
    end else begin
      state_q    <= state_d;
      hex_pend_q <= gpio_we && !dec_mode;
      if (gpio_we) begin
        val_q  <= gpio_wdata;
        mode_q <= dec_mode;
      end
      if (seg_upd) seg_q <= seg_new;
    end
  end

  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;
  assign hex0      = seg_q[0];
  assign hex1      = seg_q[1];
  assign hex2      = seg_q[2];
  assign hex3      = seg_q[3];
  assign hex4      = seg_q[4];
  assign hex5      = seg_q[5];
  assign hex6      = seg_q[6];
  assign hex7      = seg_q[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: a reference model computes the display from the
// written value with plain arithmetic and a countdown to the update edge; a
// compare process checks busy and all digits every cycle, and directed steps
// pin literal segment values.
module tb_hex_display_ctrl;
  import hex_display_pkg::*;

  localparam bit BLANK_LZ = 1'b1;
  typedef logic [7:0][6:0] segv_t;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gpio_we = 1'b0;
  logic [31:0] gpio_wdata = '0;
  logic        dec_mode = 1'b0;
  logic        busy;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  state_e      dbg_state;

  always #5 clk = ~clk;

  hex_display_ctrl #(.CONV_CYCLES(32), .BLANK_LZ(BLANK_LZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gpio_we    (gpio_we),
    .gpio_wdata (gpio_wdata),
    .dec_mode   (dec_mode),
    .busy       (busy),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .hex6       (hex6),
    .hex7       (hex7),
    .dbg_state  (dbg_state)
  );

  logic [6:0] act [8];
  assign act[0] = hex0;
  assign act[1] = hex1;
  assign act[2] = hex2;
  assign act[3] = hex3;
  assign act[4] = hex4;
  assign act[5] = hex5;
  assign act[6] = hex6;
  assign act[7] = hex7;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic segv_t calc(input logic [31:0] v, input bit dec);
    segv_t s;
    int    d [8];
    longint x;
    int    top;
    x = longint'(v);
    if (dec && x >= 100000000) return {8{7'h3F}};
    for (int i = 0; i < 8; i++) begin
      if (dec) begin
        d[i] = int'(x % 10);
        x    = x / 10;
      end else begin
        d[i] = int'((v >> (4 * i)) & 32'hF);
      end
    end
    top = 0;
    for (int i = 0; i < 8; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 8; i++) s[i] = (BLANK_LZ && i > top) ? 7'h7F : tbl[d[i]];
    return s;
  endfunction

  segv_t exp_seg;
  segv_t pend_seg;
  int    cd = 0;
  bit    pend_dec = 1'b0;
  bit    exp_busy = 1'b0;
  bit    live = 1'b0;

  // Update edge: 1 edge after capture for hex, 33 for decimal.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      cd       = 0;
      pend_dec = 1'b0;
      exp_seg  = {8{7'h7F}};
      live     = 1'b1;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0 && !(gpio_we && pend_dec)) exp_seg = pend_seg;
      end
      if (gpio_we) begin
        pend_seg = calc(gpio_wdata, dec_mode);
        pend_dec = dec_mode;
        cd       = dec_mode ? 33 : 1;
      end
    end
    exp_busy = pend_dec && cd > 0;
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("busy", {6'b0, busy}, {6'b0, exp_busy});
      for (int i = 0; i < 8; i++) chk($sformatf("hex%0d", i), act[i], exp_seg[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] v, input logic dec);
    @(negedge clk);
    gpio_we    = 1'b1;
    gpio_wdata = v;
    dec_mode   = dec;
    @(negedge clk);
    gpio_we    = 1'b0;
    gpio_wdata = $urandom;
    dec_mode   = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_all(input string name, input logic [6:0] e7, input logic [6:0] e6,
                         input logic [6:0] e5, input logic [6:0] e4, input logic [6:0] e3,
                         input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
    chk({name, "_h7"}, hex7, e7);
    chk({name, "_h6"}, hex6, e6);
    chk({name, "_h5"}, hex5, e5);
    chk({name, "_h4"}, hex4, e4);
    chk({name, "_h3"}, hex3, e3);
    chk({name, "_h2"}, hex2, e2);
    chk({name, "_h1"}, hex1, e1);
    chk({name, "_h0"}, hex0, e0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int          w;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("reset_busy", {6'b0, busy}, 7'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_all("idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Hex mode, shown one edge after capture.
    wr(32'h12AB00F0, 1'b0);
    @(negedge clk);
    chk_all("hexw", 7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h40, 7'h0E, 7'h40);
    chk("hexw_busy", {6'b0, busy}, 7'h0);

    // Decimal 12345: busy through edge 32, result on edge 33.
    wr(32'd12345, 1'b1);
    repeat (32) @(negedge clk);
    chk("dec_busy32", {6'b0, busy}, 7'h1);
    chk("dec_hold", hex0, 7'h40);
    @(negedge clk);
    chk("dec_busy33", {6'b0, busy}, 7'h0);
    chk_all("dec12345", 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);

    // Overflow and the largest in-range value.
    wr(32'hFFFFFFFF, 1'b1);
    repeat (33) @(negedge clk);
    chk_all("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
    wr(32'd99999999, 1'b1);
    repeat (33) @(negedge clk);
    chk_all("max8", 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);

    // Restart mid-conversion with zero.
    wr(32'd12345, 1'b1);
    repeat (9) @(negedge clk);
    wr(32'd0, 1'b1);
    repeat (32) @(negedge clk);
    chk("restart_busy", {6'b0, busy}, 7'h1);
    @(negedge clk);
    chk_all("restart0", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    // Hex write aborts a conversion.
    wr(32'd4321, 1'b1);
    repeat (5) @(negedge clk);
    wr(32'h0000BEEF, 1'b0);
    @(negedge clk);
    chk("abort_busy", {6'b0, busy}, 7'h0);
    chk_all("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h06, 7'h06, 7'h0E);

    // Reset in the middle of a conversion.
    wr(32'd777, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    chk("midrst_busy", {6'b0, busy}, 7'h0);
    rst_n = 1'b1;
    wr(32'h0000CAFE, 1'b0);
    @(negedge clk);
    chk_all("postrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h46, 7'h08, 7'h0E, 7'h06);

    // Randomized writes, gaps and occasional resets against the model.
    for (int n = 0; n < 60; n++) begin
      w = $urandom_range(1, 32);
      v = $urandom;
      if (w < 32) v = v & ((32'h1 << w) - 32'h1);
      if ($urandom_range(0, 9) == 0) v = 32'd100000000 - 32'($urandom_range(0, 1));
      wr(v, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 11) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
